// File: rtl/tdm_serializer8_if.sv
// rtl/tdm_serializer8_if.sv - parallel-in / slotted serial-out bundle for tdm_serializer8
//
// Signals:
//   load              frame start request from the producer
//   x0..x7            parallel channel bits, captured when a load is accepted
//   ready             serializer idle and able to accept load
//   d                 serial data bit of the current slot
//   s0, s1, s2        slot index {s2,s1,s0} for demux select lines
//   valid             d/s2..s0 carry a live slot
//   done              one-cycle pulse on the final slot of a frame
//   par_slot          high during the parity slot (0 when parity is not built)
//
// Modports: master = producer/consumer side, slave = serializer side.
interface tdm_serializer8_if;
    logic load;
    logic x0, x1, x2, x3, x4, x5, x6, x7;
    logic ready;
    logic d;
    logic s0, s1, s2;
    logic valid;
    logic done;
    logic par_slot;

    modport master (
        output load, x0, x1, x2, x3, x4, x5, x6, x7,
        input  ready, d, s0, s1, s2, valid, done, par_slot
    );

    modport slave (
        input  load, x0, x1, x2, x3, x4, x5, x6, x7,
        output ready, d, s0, s1, s2, valid, done, par_slot
    );
endinterface

// File: rtl/tdm_serializer8.sv
// rtl/tdm_serializer8.sv - 8-slot TDM serializer with optional even-parity slot
//
// Captures x7..x0 on an accepted load and emits one bit per cycle as slots
// 0..7 with the slot index on {s2,s1,s0}, then returns to IDLE for one cycle.
// Build option: define TDM_SERIALIZER8_PARITY_EN to append a parity slot
// (index 111, par_slot=1, d = XOR of the frame) after slot 7.
//
// Ports:
//   clk   sole clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   tdm_serializer8_if.slave (load, x0..x7 in; ready, d, s0..s2,
//         valid, done, par_slot out)
//
// All outputs are registers; nothing combinational reaches them from x/load.
module tdm_serializer8 (
    input  logic             clk,
    input  logic             rst,
    tdm_serializer8_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] cnt;
    logic [7:0] frame;
    logic [2:0] cnt_inc;

    assign cnt_inc = cnt + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 3'd0;
            frame        <= 8'h00;
            bus.ready    <= 1'b1;
            bus.valid    <= 1'b0;
            bus.d        <= 1'b0;
            {bus.s2, bus.s1, bus.s0} <= 3'b000;
            bus.done     <= 1'b0;
            bus.par_slot <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        frame <= {bus.x7, bus.x6, bus.x5, bus.x4,
                                  bus.x3, bus.x2, bus.x1, bus.x0};
                        cnt          <= 3'd0;
                        state        <= SHIFT;
                        bus.ready    <= 1'b0;
                        bus.valid    <= 1'b1;
                        // Slot 0 is registered straight from x0 so it shows
                        // in the cycle right after the accepting edge.
                        bus.d        <= bus.x0;
                        {bus.s2, bus.s1, bus.s0} <= 3'b000;
                        bus.done     <= 1'b0;
                        bus.par_slot <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (cnt == 3'd7) begin
`ifdef TDM_SERIALIZER8_PARITY_EN
                        state        <= PAR;
                        bus.valid    <= 1'b1;
                        bus.d        <= ^frame;
                        {bus.s2, bus.s1, bus.s0} <= 3'b111;
                        bus.done     <= 1'b1;
                        bus.par_slot <= 1'b1;
`else
                        state        <= IDLE;
                        cnt          <= 3'd0;
                        bus.ready    <= 1'b1;
                        bus.valid    <= 1'b0;
                        bus.d        <= 1'b0;
                        {bus.s2, bus.s1, bus.s0} <= 3'b000;
                        bus.done     <= 1'b0;
                        bus.par_slot <= 1'b0;
`endif
                    end else begin
                        cnt   <= cnt_inc;
                        bus.d <= frame[cnt_inc];
                        {bus.s2, bus.s1, bus.s0} <= cnt_inc;
                        // done is raised as we move onto slot 7 so the pulse
                        // coincides with the last data slot.
`ifdef TDM_SERIALIZER8_PARITY_EN
                        bus.done <= 1'b0;
`else
                        bus.done <= (cnt_inc == 3'd7);
`endif
                    end
                end

                PAR: begin
                    state        <= IDLE;
                    cnt          <= 3'd0;
                    bus.ready    <= 1'b1;
                    bus.valid    <= 1'b0;
                    bus.d        <= 1'b0;
                    {bus.s2, bus.s1, bus.s0} <= 3'b000;
                    bus.done     <= 1'b0;
                    bus.par_slot <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_serializer8.sv
// tb/tb_tdm_serializer8.sv - self-checking bench for tdm_serializer8
module tb_tdm_serializer8;

`ifdef TDM_SERIALIZER8_PARITY_EN
    localparam bit PARITY = 1'b1;
`else
    localparam bit PARITY = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    tdm_serializer8_if bus ();

    tdm_serializer8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_x(input logic [7:0] v);
        {bus.x7, bus.x6, bus.x5, bus.x4, bus.x3, bus.x2, bus.x1, bus.x0} = v;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " ready"}, {7'd0, bus.ready}, 8'd1);
        check({tag, " valid"}, {7'd0, bus.valid}, 8'd0);
        check({tag, " d"}, {7'd0, bus.d}, 8'd0);
        check({tag, " slot"}, {5'd0, bus.s2, bus.s1, bus.s0}, 8'd0);
        check({tag, " done"}, {7'd0, bus.done}, 8'd0);
        check({tag, " par_slot"}, {7'd0, bus.par_slot}, 8'd0);
    endtask

    // Checks one live slot against the frame byte; also drives a 1-to-8
    // demux from s/d and requires yN == xN on the selected line.
    task automatic check_slot(input string tag, input logic [7:0] b, input int i);
        logic [7:0] y;
        logic [7:0] want_y;
        y = 8'd0;
        y[{bus.s2, bus.s1, bus.s0}] = bus.d;
        want_y = b & (8'd1 << i);
        check($sformatf("%s slot%0d valid", tag, i), {7'd0, bus.valid}, 8'd1);
        check($sformatf("%s slot%0d ready", tag, i), {7'd0, bus.ready}, 8'd0);
        check($sformatf("%s slot%0d d", tag, i), {7'd0, bus.d}, {7'd0, b[i]});
        check($sformatf("%s slot%0d idx", tag, i), {5'd0, bus.s2, bus.s1, bus.s0}, 8'(i));
        check($sformatf("%s slot%0d done", tag, i), {7'd0, bus.done},
              {7'd0, (i == 7) && !PARITY});
        check($sformatf("%s slot%0d par_slot", tag, i), {7'd0, bus.par_slot}, 8'd0);
        check($sformatf("%s slot%0d demux", tag, i), y, want_y);
    endtask

    // Called at a negedge while the DUT is idle. Ends at the negedge of the
    // idle cycle that follows the frame, leaving load = hold.
    task automatic run_frame(input string tag, input logic [7:0] b, input bit hold,
                             input bit scramble, input logic [7:0] x_mid);
        set_x(b);
        bus.load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check_slot(tag, b, i);
            if (scramble) begin
                set_x(x_mid ^ 8'(i * 37));
                bus.load = hold ? 1'b1 : 1'($urandom_range(0, 1));
            end else begin
                set_x(x_mid);
                bus.load = hold;
            end
            @(negedge clk);
        end
        if (PARITY) begin
            check({tag, " par valid"}, {7'd0, bus.valid}, 8'd1);
            check({tag, " par d"}, {7'd0, bus.d}, {7'd0, ^b});
            check({tag, " par idx"}, {5'd0, bus.s2, bus.s1, bus.s0}, 8'd7);
            check({tag, " par par_slot"}, {7'd0, bus.par_slot}, 8'd1);
            check({tag, " par done"}, {7'd0, bus.done}, 8'd1);
            check({tag, " par ready"}, {7'd0, bus.ready}, 8'd0);
            @(negedge clk);
        end
        check_idle({tag, " idle"});
        bus.load = hold;
    endtask

    initial begin
        logic [7:0] b;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.load = 1'b0;
        set_x(8'h00);
        #1;
        check_idle("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("post-reset");
        @(negedge clk);
        check_idle("no-load");

        // Directed frame 1010_0110: d = 0,1,1,0,0,1,0,1, even parity 0.
        run_frame("a6", 8'hA6, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check_idle("a6 after");

        // load held high, x forced to FF mid-frame: current frame stays 00,
        // next frame follows after exactly one idle cycle with FF.
        run_frame("hold00", 8'h00, 1'b1, 1'b0, 8'hFF);
        run_frame("holdff", 8'hFF, 1'b0, 1'b0, 8'h00);

        // Mid-frame reset at slot 4 of 5A, applied between clock edges.
        set_x(8'h5A);
        bus.load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.load = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check_slot("5a", 8'h5A, 4);
        #2;
        rst = 1'b1;
        #1;
        check_idle("async rst");
        @(negedge clk);
        check_idle("rst held");
        rst = 1'b0;
        @(negedge clk);
        check_idle("rst released");
        run_frame("81", 8'h81, 1'b0, 1'b0, 8'h00);

        // Random frames with x and load churning during the frame.
        for (int k = 0; k < 12; k++) begin
            b = 8'($urandom);
            run_frame($sformatf("rnd%0d", k), b, 1'b0, 1'b1, 8'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check_idle($sformatf("rnd%0d gap", k));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_serializer8.md
TDM_SERIALIZER8 -- requirements
Module: tdm_serializer8

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-003 SHALL have port load, input, 1, frame start request, sampled only while ready=1.
REQ-004 SHALL have ports x0..x7, input, 1 each, parallel channel bits captured on accepted load.
REQ-005 SHALL have port ready, output, 1, high when idle and able to accept load.
REQ-006 SHALL have port d, output, 1, serial data bit for the current slot.
REQ-007 SHALL have ports s0, s1, s2, output, 1 each, slot index {s2,s1,s0} for the demux select lines.
REQ-008 SHALL have port valid, output, 1, high while d/s2..s0 carry a live slot.
REQ-009 SHALL have port done, output, 1, one-cycle pulse on the final slot of a frame.
REQ-010 SHALL have port par_slot, output, 1, high during the parity slot (tied 0 when the parity slot is not compiled in).

Function
REQ-011 SHALL implement states IDLE, SHIFT and, when compiled in, PAR.
REQ-012 IDLE: ready=1, valid=0, d=0, {s2,s1,s0}=000, done=0, par_slot=0.
REQ-013 IDLE + load=1 at edge k SHALL capture x7..x0 into an 8-bit frame register, clear slot counter to 0, enter SHIFT at edge k.
REQ-014 SHIFT: valid=1, ready=0, d=frame[cnt], {s2,s1,s0}=cnt; cnt increments by 1 per cycle.
REQ-015 First slot (cnt=0, d=x0) SHALL be visible in the cycle after edge k; latency load->first valid = 1 cycle.
REQ-016 cnt=7 with parity not compiled in: done=1 that cycle, next state IDLE, cnt wraps to 0.
REQ-017 cnt=7 with parity compiled in: done=0, next state PAR.
REQ-018 load and x0..x7 SHALL be ignored in SHIFT and PAR; the captured frame SHALL NOT change mid-frame.
REQ-019 Frame period SHALL be 9 cycles (8 slots + 1 IDLE) without parity, 10 with parity; no back-to-back frames without the IDLE cycle.
REQ-020 load held high continuously SHALL start a new frame on every IDLE cycle.
REQ-021 Outputs d, s2..s0, valid, done, par_slot, ready SHALL be registered or decoded only from registered state; no combinational path from x0..x7 or load to outputs.

Reset
REQ-022 rst=1 SHALL immediately, without waiting for clk, force IDLE, cnt=000, frame register=0x00, ready=1, valid=0, d=0, s2..s0=000, done=0, par_slot=0.
REQ-023 rst asserted mid-frame SHALL discard the frame; no done pulse; after release the first rising edge with load=1 starts a fresh frame.
REQ-024 load sampled on the same edge rst deasserts SHALL be accepted only if rst is already low at that edge.

Configuration
REQ-025 Macro TDM_SERIALIZER8_PARITY_EN SHALL select the parity slot.
REQ-026 Defined: PAR state follows slot 7 for one cycle with valid=1, par_slot=1, {s2,s1,s0}=111, d=even parity (XOR of frame[7:0]), done=1; then IDLE.
REQ-027 Undefined: no PAR state, par_slot constant 0, behaviour per REQ-016.

Verification
REQ-028 rst pulsed mid-cycle with clk stopped -> all outputs reach reset values of REQ-022 before next clk edge.
REQ-029 x7..x0=8'b1010_0110, load one cycle -> slots 0..7 give d=0,1,1,0,0,1,0,1 with {s2,s1,s0}=000..111, done=1 only at slot 7 (no parity build).
REQ-030 Same frame, parity build -> after slot 7 one PAR cycle d=0 (four ones), par_slot=1, done=1; ready returns 1 next cycle.
REQ-031 load held high, x changed to 8'hFF during SHIFT of frame 8'h00 -> current frame d all 0; next frame starts after one IDLE cycle, carrying 8'hFF.
REQ-032 rst asserted at slot 4 of frame 8'h5A -> no done, ready=1 immediately; next load of 8'h81 produces d=1,0,0,0,0,0,0,1.
REQ-033 Outputs s2..s0,d driven into a 1-to-8 demux -> demux output yN equals xN for every slot of each frame.
